// File: rtl/lane_scheduler_if.sv
// Command-list fetch port of lane_scheduler.
// Handshake: list_req rises and is held until a cycle in which list_valid is high;
// list_cmd is transferred in that cycle and list_req drops on the following edge.
interface lane_scheduler_if #(
  parameter int CMD_W = 4
);
  logic             list_req;
  logic             list_valid;
  logic [CMD_W-1:0] list_cmd;

  modport master (
    output list_req,
    input  list_valid,
    input  list_cmd
  );

  modport slave (
    input  list_req,
    output list_valid,
    output list_cmd
  );
endinterface

// File: rtl/lane_scheduler.sv
// Arbitrates lane refill requests onto the shared command list and keeps the game score.
// Optional macro FIXED_PRIORITY_EN: lowest-index pending lane wins instead of round-robin.
module lane_scheduler #(
  parameter int N_LANES  = 8,
  parameter int CMD_W    = 4,
  parameter int SCORE_W  = 8,
  parameter int LIST_LEN = 203
) (
  input  logic                CLOCK_25,
  input  logic                rst,
  input  logic [N_LANES-1:0]  lane_req,
  input  logic [N_LANES-1:0]  lane_hit,
  lane_scheduler_if.master    list,
  output logic [CMD_W-1:0]    lane_cmd,
  output logic [N_LANES-1:0]  lane_load,
  output logic [SCORE_W-1:0]  score,
  output logic [8:0]          load_count,
  output logic                game_over,
  output logic                busy,
  output logic [1:0]          o_dbg_state
);
  localparam int GW = (N_LANES > 1) ? $clog2(N_LANES) : 1;
  localparam int SW = SCORE_W + 4;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_LOAD, S_DONE} state_t;

  state_t               r_state;
  logic [N_LANES-1:0]   r_req_d, r_hit_d, r_pending, r_lane_load;
  logic [GW-1:0]        r_grant;
  logic [CMD_W-1:0]     r_lane_cmd;
  logic [SCORE_W-1:0]   r_score;
  logic [8:0]           r_load_count;
  logic                 r_list_req, r_game_over, r_busy;
`ifndef FIXED_PRIORITY_EN
  logic [GW-1:0]        r_rr;
`endif

  logic [N_LANES-1:0]   w_req_rise, w_hit_rise, w_grant_oh, w_clr;
  logic [GW-1:0]        w_pick;
  logic [SW-1:0]        w_hits, w_sum;
  logic [SCORE_W-1:0]   w_score_next;
  logic [GW-1:0]        w_grant_inc;

  assign w_req_rise  = lane_req & ~r_req_d;
  assign w_hit_rise  = lane_hit & ~r_hit_d;
  assign w_grant_oh  = {{(N_LANES-1){1'b0}}, 1'b1} << r_grant;
  assign w_clr       = (r_state == S_LOAD) ? w_grant_oh : '0;
  assign w_grant_inc = (int'(r_grant) == N_LANES - 1) ? '0 : r_grant + 1'b1;

  always_comb begin
    w_hits = '0;
    for (int i = 0; i < N_LANES; i++) begin
      w_hits = w_hits + {{(SW-1){1'b0}}, w_hit_rise[i]};
    end
    w_sum = {4'b0000, r_score} + w_hits;
    w_score_next = (w_sum > {4'b0000, {SCORE_W{1'b1}}}) ? {SCORE_W{1'b1}} : w_sum[SCORE_W-1:0];
  end

  // Scan downward so the first hit in search order is the last one written.
  always_comb begin
    w_pick = '0;
`ifdef FIXED_PRIORITY_EN
    for (int i = N_LANES - 1; i >= 0; i--) begin
      if (r_pending[i]) w_pick = GW'(i);
    end
`else
    for (int k = N_LANES - 1; k >= 0; k--) begin
      if (r_pending[(int'(r_rr) + k) % N_LANES]) w_pick = GW'((int'(r_rr) + k) % N_LANES);
    end
`endif
  end

  always_ff @(posedge CLOCK_25) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_req_d      <= '0;
      r_hit_d      <= '0;
      r_pending    <= '0;
      r_lane_load  <= '0;
      r_grant      <= '0;
      r_lane_cmd   <= '0;
      r_score      <= '0;
      r_load_count <= '0;
      r_list_req   <= 1'b0;
      r_game_over  <= 1'b0;
      r_busy       <= 1'b0;
`ifndef FIXED_PRIORITY_EN
      r_rr         <= '0;
`endif
    end else begin
      r_req_d     <= lane_req;
      r_hit_d     <= lane_hit;
      r_lane_load <= '0;
      // A new rise in the clearing cycle keeps the lane pending.
      if (r_state != S_DONE) begin
        r_pending <= (r_pending & ~w_clr) | w_req_rise;
        r_score   <= w_score_next;
      end else begin
        r_pending <= '0;
      end
      case (r_state)
        S_IDLE: begin
          if (|r_pending) begin
            r_grant    <= w_pick;
            r_list_req <= 1'b1;
            r_busy     <= 1'b1;
            r_state    <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (list.list_valid) begin
            r_lane_cmd  <= list.list_cmd;
            r_lane_load <= w_grant_oh;
            r_list_req  <= 1'b0;
            r_state     <= S_LOAD;
          end
        end
        S_LOAD: begin
          r_load_count <= r_load_count + 9'd1;
          r_busy       <= 1'b0;
`ifndef FIXED_PRIORITY_EN
          r_rr         <= w_grant_inc;
`endif
          if (r_load_count == 9'(LIST_LEN - 1)) begin
            r_game_over <= 1'b1;
            r_state     <= S_DONE;
          end else begin
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_DONE;
      endcase
    end
  end

  assign list.list_req = r_list_req;
  assign lane_cmd      = r_lane_cmd;
  assign lane_load     = r_lane_load;
  assign score         = r_score;
  assign load_count    = r_load_count;
  assign game_over     = r_game_over;
  assign busy          = r_busy;
  assign o_dbg_state   = r_state;
endmodule

// File: tb/tb_lane_scheduler.sv
// Directed bench for lane_scheduler: default-length instance plus a LIST_LEN=4 instance.
module tb_lane_scheduler;
  logic clk = 1'b0;
  always #20 clk = ~clk;

  logic       rst;
  logic [7:0] req, hit, req2, hit2;
  logic [3:0] lcmd, lcmd2;
  logic [7:0] load, load2;
  logic [7:0] score, score2;
  logic [8:0] cnt, cnt2;
  logic       gover, gover2, busy, busy2;
  logic [1:0] dbg, dbg2;
  int n_cmp = 0;
  int n_err = 0;

  lane_scheduler_if #(.CMD_W(4)) lif ();
  lane_scheduler_if #(.CMD_W(4)) lif2 ();

  lane_scheduler #(.N_LANES(8), .CMD_W(4), .SCORE_W(8), .LIST_LEN(203)) dut (
    .CLOCK_25(clk), .rst(rst), .lane_req(req), .lane_hit(hit), .list(lif),
    .lane_cmd(lcmd), .lane_load(load), .score(score), .load_count(cnt),
    .game_over(gover), .busy(busy), .o_dbg_state(dbg));

  lane_scheduler #(.N_LANES(8), .CMD_W(4), .SCORE_W(8), .LIST_LEN(4)) dut2 (
    .CLOCK_25(clk), .rst(rst), .lane_req(req2), .lane_hit(hit2), .list(lif2),
    .lane_cmd(lcmd2), .lane_load(load2), .score(score2), .load_count(cnt2),
    .game_over(gover2), .busy(busy2), .o_dbg_state(dbg2));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1; req = '0; hit = '0; req2 = '0; hit2 = '0;
    lif.list_valid = 1'b0; lif.list_cmd = '0;
    lif2.list_valid = 1'b0; lif2.list_cmd = '0;
    tick; tick;
    rst = 1'b0;
  endtask

  // Returns the first nonzero load strobe within 20 cycles, or zero on timeout.
  task automatic wait_load(output logic [7:0] ld, output logic [3:0] c);
    ld = '0; c = '0;
    for (int i = 0; i < 20; i++) begin
      tick;
      if (load !== 8'h00) begin
        ld = load; c = lcmd;
        break;
      end
    end
  endtask

  task automatic test_reset;
    req = 8'hFF; hit = 8'hFF; lif.list_valid = 1'b1;
    tick; tick;
    do_reset;
    n_cmp++; if (lif.list_req !== 1'b0) begin n_err++; $display("FAIL reset_list_req: got %b want 0", lif.list_req); end
    n_cmp++; if ({lcmd, load} !== 12'h000) begin n_err++; $display("FAIL reset_cmd_load: got %h want 000", {lcmd, load}); end
    n_cmp++; if ({score, cnt} !== 17'h0) begin n_err++; $display("FAIL reset_score_count: got %h want 0", {score, cnt}); end
    n_cmp++; if ({gover, busy, dbg} !== 4'b0000) begin n_err++; $display("FAIL reset_flags: got %b want 0000", {gover, busy, dbg}); end
  endtask

  task automatic test_basic_load;
    do_reset;
    lif.list_valid = 1'b1; lif.list_cmd = 4'b0101;
    req = 8'b0000_1000;
    tick;
    n_cmp++; if (lif.list_req !== 1'b0) begin n_err++; $display("FAIL basic_req_early: got %b want 0", lif.list_req); end
    tick;
    n_cmp++; if ({lif.list_req, busy} !== 2'b11) begin n_err++; $display("FAIL basic_fetch: got %b want 11", {lif.list_req, busy}); end
    tick;
    n_cmp++; if (load !== 8'b0000_1000) begin n_err++; $display("FAIL basic_load: got %b want 00001000", load); end
    n_cmp++; if (lcmd !== 4'b0101) begin n_err++; $display("FAIL basic_cmd: got %b want 0101", lcmd); end
    tick;
    n_cmp++; if ({load, cnt} !== {8'h00, 9'd1}) begin n_err++; $display("FAIL basic_after: load %b count %0d want 0/1", load, cnt); end
    tick; tick; tick; tick;
    n_cmp++; if (cnt !== 9'd1) begin n_err++; $display("FAIL basic_held_level: count %0d want 1", cnt); end
    req = '0;
  endtask

  task automatic test_round_robin;
    logic [7:0] ld;
    logic [3:0] c;
    logic [7:0] exp_a, exp_b;
    do_reset;
    lif.list_valid = 1'b1; lif.list_cmd = 4'hA;
    req = 8'b0110_0010;
    tick;
    req = '0;
    wait_load(ld, c);
    n_cmp++; if (ld !== 8'h02) begin n_err++; $display("FAIL rr_first: got %b want 00000010", ld); end
    n_cmp++; if (c !== 4'hA) begin n_err++; $display("FAIL rr_cmd: got %h want a", c); end
    wait_load(ld, c);
    n_cmp++; if (ld !== 8'h20) begin n_err++; $display("FAIL rr_second: got %b want 00100000", ld); end
    wait_load(ld, c);
    n_cmp++; if (ld !== 8'h40) begin n_err++; $display("FAIL rr_third: got %b want 01000000", ld); end
    // Pointer now sits at lane 7: lanes 2 and 7 together separate the two policies.
    req = 8'b1000_0100;
    tick;
    req = '0;
`ifdef FIXED_PRIORITY_EN
    exp_a = 8'h04; exp_b = 8'h80;
`else
    exp_a = 8'h80; exp_b = 8'h04;
`endif
    wait_load(ld, c);
    n_cmp++; if (ld !== exp_a) begin n_err++; $display("FAIL rr_pair_first: got %b want %b", ld, exp_a); end
    wait_load(ld, c);
    n_cmp++; if (ld !== exp_b) begin n_err++; $display("FAIL rr_pair_second: got %b want %b", ld, exp_b); end
    tick;
    n_cmp++; if (cnt !== 9'd5) begin n_err++; $display("FAIL rr_count: got %0d want 5", cnt); end
  endtask

  task automatic test_delayed_valid;
    logic [7:0] ld;
    logic [3:0] c;
    int hi;
    int strobes;
    do_reset;
    lif.list_valid = 1'b0; lif.list_cmd = 4'h3;
    req = 8'h04;
    tick;
    req = '0;
    tick;
    hi = (lif.list_req === 1'b1) ? 1 : 0;
    strobes = 0;
    req = 8'h10;
    for (int i = 0; i < 5; i++) begin
      tick;
      req = '0;
      if (lif.list_req === 1'b1) hi++;
      if (load !== 8'h00) strobes++;
    end
    lif.list_valid = 1'b1;
    tick;
    n_cmp++; if (hi !== 6) begin n_err++; $display("FAIL delay_req_cycles: got %0d want 6", hi); end
    n_cmp++; if (strobes !== 0) begin n_err++; $display("FAIL delay_early_load: got %0d want 0", strobes); end
    n_cmp++; if ({load, lif.list_req} !== {8'h04, 1'b0}) begin n_err++; $display("FAIL delay_load: got %b/%b want 00000100/0", load, lif.list_req); end
    wait_load(ld, c);
    n_cmp++; if (ld !== 8'h10) begin n_err++; $display("FAIL delay_next_lane: got %b want 00010000", ld); end
    tick;
    n_cmp++; if (cnt !== 9'd2) begin n_err++; $display("FAIL delay_count: got %0d want 2", cnt); end
  endtask

  task automatic test_score;
    do_reset;
    hit = 8'h01;
    tick; tick; tick; tick; tick;
    n_cmp++; if (score !== 8'd1) begin n_err++; $display("FAIL score_held: got %0d want 1", score); end
    hit = '0;
    tick;
    for (int i = 0; i < 31; i++) begin
      hit = 8'hFF; tick;
      hit = 8'h00; tick;
    end
    n_cmp++; if (score !== 8'd249) begin n_err++; $display("FAIL score_all_lanes: got %0d want 249", score); end
    hit = 8'h0F; tick; hit = 8'h00; tick;
    n_cmp++; if (score !== 8'd253) begin n_err++; $display("FAIL score_253: got %0d want 253", score); end
    hit = 8'b0000_0111; tick;
    n_cmp++; if (score !== 8'd255) begin n_err++; $display("FAIL score_saturate: got %0d want 255", score); end
    hit = 8'h00; tick;
    hit = 8'hFF; tick; hit = 8'h00; tick;
    n_cmp++; if (score !== 8'd255) begin n_err++; $display("FAIL score_stay_sat: got %0d want 255", score); end
  endtask

  task automatic test_game_over;
    int strobes;
    int bad;
    do_reset;
    lif2.list_valid = 1'b1; lif2.list_cmd = 4'h6;
    req2 = 8'h3F; hit2 = 8'h03;
    tick;
    req2 = '0; hit2 = '0;
    strobes = 0; bad = 0;
    for (int i = 0; i < 40; i++) begin
      tick;
      if (load2 !== 8'h00) strobes++;
      if (gover2 === 1'b1 && (lif2.list_req !== 1'b0 || load2 !== 8'h00)) bad++;
    end
    n_cmp++; if (strobes !== 4) begin n_err++; $display("FAIL done_loads: got %0d want 4", strobes); end
    n_cmp++; if ({gover2, busy2, dbg2} !== 4'b1011) begin n_err++; $display("FAIL done_flags: got %b want 1011", {gover2, busy2, dbg2}); end
    n_cmp++; if (cnt2 !== 9'd4) begin n_err++; $display("FAIL done_count: got %0d want 4", cnt2); end
    n_cmp++; if (score2 !== 8'd2) begin n_err++; $display("FAIL done_score_before: got %0d want 2", score2); end
    req2 = 8'h80; hit2 = 8'hFF;
    tick;
    req2 = '0; hit2 = '0;
    for (int i = 0; i < 8; i++) begin
      tick;
      if (lif2.list_req !== 1'b0 || load2 !== 8'h00) bad++;
    end
    n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL done_activity: got %0d want 0", bad); end
    n_cmp++; if (score2 !== 8'd2) begin n_err++; $display("FAIL done_score_frozen: got %0d want 2", score2); end
  endtask

  task automatic test_reset_mid_fetch;
    logic [7:0] ld;
    logic [3:0] c;
    do_reset;
    lif.list_valid = 1'b0; lif.list_cmd = 4'h9;
    hit = 8'h01;
    req = 8'h40;
    tick;
    req = '0; hit = '0;
    tick;
    n_cmp++; if (lif.list_req !== 1'b1) begin n_err++; $display("FAIL midrst_fetch: got %b want 1", lif.list_req); end
    tick;
    rst = 1'b1; lif.list_valid = 1'b1;
    tick;
    n_cmp++; if ({load, lif.list_req, busy, gover} !== 11'h000) begin n_err++; $display("FAIL midrst_outputs: got %h want 000", {load, lif.list_req, busy, gover}); end
    n_cmp++; if ({lcmd, score, cnt, dbg} !== 23'h0) begin n_err++; $display("FAIL midrst_state: got %h want 0", {lcmd, score, cnt, dbg}); end
    rst = 1'b0;
    tick; tick;
    n_cmp++; if ({load, lif.list_req} !== 9'h000) begin n_err++; $display("FAIL midrst_no_load: got %h want 000", {load, lif.list_req}); end
    req = 8'h04;
    tick;
    req = '0;
    wait_load(ld, c);
    n_cmp++; if ({ld, c} !== {8'h04, 4'h9}) begin n_err++; $display("FAIL midrst_fresh: got %h want 049", {ld, c}); end
    tick;
    n_cmp++; if (cnt !== 9'd1) begin n_err++; $display("FAIL midrst_count: got %0d want 1", cnt); end
  endtask

  initial begin
    rst = 1'b1; req = '0; hit = '0; req2 = '0; hit2 = '0;
    lif.list_valid = 1'b0; lif.list_cmd = '0;
    lif2.list_valid = 1'b0; lif2.list_cmd = '0;
    test_reset;
    test_basic_load;
    test_round_robin;
    test_delayed_valid;
    test_score;
    test_game_over;
    test_reset_mid_fetch;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
    $fatal(1, "time limit");
  end
endmodule
